// File: rtl/pls_dac_pkg.sv
// Shared types and conversion helpers for the PLS DAC feeder.
// Arithmetic is done at a fixed 64-bit working width, and callers truncate the result.
package pls_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int CALC_W = 64;

  function automatic logic [CALC_W-1:0] dac_midscale(input int dac_w);
    return CALC_W'(1) << (dac_w - 1);
  endfunction

  function automatic logic is_clipped(input logic signed [CALC_W-1:0] x, input int dac_w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = signed'(dac_midscale(dac_w)) - 64'sd1;
    lo = -signed'(dac_midscale(dac_w));
    return (x > hi) || (x < lo);
  endfunction

  // Clamp to the signed dac_w range, then flip the MSB to get offset-binary.
  function automatic logic [CALC_W-1:0] sat_offset_bin(input logic signed [CALC_W-1:0] x,
                                                      input int dac_w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    logic signed [CALC_W-1:0] s;
    hi = signed'(dac_midscale(dac_w)) - 64'sd1;
    lo = -signed'(dac_midscale(dac_w));
    if (x > hi)      s = hi;
    else if (x < lo) s = lo;
    else             s = x;
    return (s ^ dac_midscale(dac_w)) & ((dac_midscale(dac_w) << 1) - CALC_W'(1));
  endfunction

endpackage

// File: rtl/pls_sync_fifo.sv
// Single-clock sample FIFO whose full and empty flags come from the level counter.
// A push while full is dropped, even if a pop happens in the same cycle.
module pls_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pls_dac_feeder.sv
// Buffers generator samples and releases one to the DAC every (rate_div+1) cycles.
// Samples are saturated and converted to offset-binary on the way out.
module pls_dac_feeder
  import pls_dac_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int DAC_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  input  logic                          status_clear,
  input  logic [DATA_SIZE-1:0]          s_tdata,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  output logic                          s_tready,
  output logic [DAC_WIDTH-1:0]          dac_data,
  output logic                          dac_strobe,
  output logic                          underflow,
  output logic                          clipped,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_WIDTH-1:0] MIDSCALE  = DAC_WIDTH'(dac_midscale(DAC_WIDTH));
  localparam logic [LVL_W-1:0]     PRIME_LVL = LVL_W'(FIFO_DEPTH / 2);

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DAC_WIDTH-1:0]   dac_data_q, dac_data_d;
  logic                   strobe_q, strobe_d;
  logic                   underflow_q, underflow_d;
  logic                   clipped_q, clipped_d;

  logic [DATA_SIZE-1:0]        fifo_rd_data;
  logic signed [DATA_SIZE-1:0] rd_data_s;
  logic                        fifo_full, fifo_empty;
  logic                        push, pop, tick;
  logic [DAC_WIDTH-1:0]        conv_data;
  logic                        conv_clip;
  logic                        unused_tlast;

  assign unused_tlast = s_tlast;
  assign rd_data_s    = fifo_rd_data;
  assign s_tready     = (state_q != ST_IDLE) && !fifo_full;
  assign push         = s_tvalid && s_tready;
  assign tick         = enable && (state_q == ST_RUN) && (cnt_q == '0);
  assign pop          = tick && !fifo_empty;

  pls_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .flush   (!enable),
    .push    (push),
    .pop     (pop),
    .wr_data (s_tdata),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    conv_data   = DAC_WIDTH'(sat_offset_bin(CALC_W'(rd_data_s), DAC_WIDTH));
    conv_clip   = is_clipped(CALC_W'(rd_data_s), DAC_WIDTH);
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    dac_data_d  = dac_data_q;
    strobe_d    = pop;
    underflow_d = status_clear ? 1'b0 : underflow_q;
    clipped_d   = status_clear ? 1'b0 : clipped_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_PRIME;
          div_d   = rate_div;
        end
      end
      ST_PRIME: begin
        // Counter starts at zero so the first RUN cycle ticks, then reloads the divider.
        if (fifo_level >= PRIME_LVL) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = (cnt_q == '0) ? div_q : cnt_q - DIV_WIDTH'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) dac_data_d = conv_data;
    if (pop && conv_clip) clipped_d = 1'b1;
    if (tick && fifo_empty) underflow_d = 1'b1;

    if (!enable) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      dac_data_d = MIDSCALE;
      strobe_d   = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      dac_data_q  <= MIDSCALE;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
      clipped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      dac_data_q  <= dac_data_d;
      strobe_q    <= strobe_d;
      underflow_q <= underflow_d;
      clipped_q   <= clipped_d;
    end
  end

  assign dac_data   = dac_data_q;
  assign dac_strobe = strobe_q;
  assign underflow  = underflow_q;
  assign clipped    = clipped_q;

endmodule
